// File: rtl/nn_pkg.sv
// Shared types and defaults for the neuron MAC datapath.
//   neuron_state_t : sequencer states (IDLE -> MAC -> BIAS -> ACT -> IDLE)
//   min_acc_w()    : smallest accumulator width that cannot overflow during MAC
//   NN_*           : default sizes used by the neuron tops
package nn_pkg;

  localparam int NN_N_IN  = 10;
  localparam int NN_DW    = 8;
  localparam int NN_WW    = 8;
  localparam int NN_ACC_W = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_BIAS = 2'd2,
    S_ACT  = 2'd3
  } neuron_state_t;

  // Full product width plus growth for summing n_in terms, plus one bit of
  // headroom so the bias add cannot wrap on the worst-case MAC sum.
  function automatic int min_acc_w(input int n_in, input int dw, input int ww);
    return dw + ww + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/neuron_act_sat.sv
// Output stage of a neuron: arithmetic right shift, optional ReLU, then
// saturation to a signed OUT_W result. Purely combinational.
//   acc : signed accumulator value (ACC_W)
//   y   : activated, saturated result (OUT_W)
module neuron_act_sat #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 0,
  parameter int OUT_W = 8,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] y
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] t;

  always_comb begin
    t = acc >>> SHIFT;
    y = t[OUT_W-1:0];
    if ((RELU != 0) && (t < 0)) begin
      y = '0;
    end else if (t > MAX_V) begin
      y = MAX_V[OUT_W-1:0];
    end else if (t < MIN_V) begin
      y = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential multiply-accumulate output neuron. One weight per cycle is
// fetched from an external ROM via w_addr; activations are latched at start.
//   clk, rst_n     : clock, synchronous active-low reset
//   start, abort   : request (IDLE only) / cancel (busy states only)
//   act_in         : packed signed activations, a[i] = act_in[i*DW +: DW]
//   w_in, w_addr   : ROM data (same cycle) and index, index 0 outside MAC
//   bias           : signed bias, sampled in BIAS
//   busy, done, y  : in-progress flag, one-cycle result strobe, held result
//
// state  | meaning
// IDLE   | waiting for start
// MAC    | accumulate a[idx]*w_in, one input per cycle
// BIAS   | add sign-extended bias
// ACT    | register activated result, pulse done next cycle
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int N_IN  = NN_N_IN,
  parameter int DW    = NN_DW,
  parameter int WW    = NN_WW,
  parameter int BW    = 8,
  parameter int ACC_W = NN_ACC_W,
  parameter int SHIFT = 0,
  parameter int OUT_W = 8,
  parameter int RELU  = 1,
  localparam int AW   = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_IN*DW-1:0]   act_in,
  input  logic [WW-1:0]        w_in,
  output logic [AW-1:0]        w_addr,
  input  logic [BW-1:0]        bias,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_W-1:0]     y
);

  if (ACC_W < min_acc_w(N_IN, DW, WW)) begin : g_bad_acc_w
    $error("neuron_mac_seq: ACC_W too small for N_IN/DW/WW");
  end
  if (SHIFT < 0 || SHIFT > ACC_W-1) begin : g_bad_shift
    $error("neuron_mac_seq: SHIFT out of range");
  end

  localparam logic [AW-1:0] LAST_IDX = AW'(N_IN-1);

  neuron_state_t           state_q;
  logic [AW-1:0]           idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [N_IN*DW-1:0]      act_q;
  logic [OUT_W-1:0]        y_q;
  logic                    done_q;

  logic signed [DW-1:0]    a_cur;
  logic signed [WW-1:0]    w_cur;
  logic signed [BW-1:0]    bias_s;
  logic signed [DW+WW-1:0] prod;
  logic signed [OUT_W-1:0] y_sat;

  always_comb begin
    a_cur  = act_q[idx_q*DW +: DW];
    w_cur  = w_in;
    bias_s = bias;
    prod   = (DW+WW)'(a_cur) * (DW+WW)'(w_cur);
  end

  neuron_act_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .RELU  (RELU)
  ) u_act_sat (
    .acc (acc_q),
    .y   (y_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      act_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // abort outranks normal sequencing but never touches y
      if (state_q != S_IDLE && abort) begin
        state_q <= S_IDLE;
        idx_q   <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              act_q   <= act_in;
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= S_MAC;
            end
          end
          S_MAC: begin
            acc_q <= acc_q + ACC_W'(prod);
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= S_BIAS;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
          S_BIAS: begin
            acc_q   <= acc_q + ACC_W'(bias_s);
            state_q <= S_ACT;
          end
          S_ACT: begin
            y_q     <= y_sat;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign w_addr = (state_q == S_MAC) ? idx_q : '0;
  assign done   = done_q;
  assign y      = y_q;

endmodule
